// File: rtl/boot_loader_pkg.sv
// Shared definitions for the framed byte-stream program loader.
// FSM state encodings are kept as plain 3-bit constants so they stay legacy-compatible.
package boot_loader_pkg;

  localparam logic [2:0] S_BASE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam int HDR_BYTES = 8;

endpackage

// File: rtl/boot_word_assembler.sv
// Little-endian byte-to-word assembler: the first byte lands in bits [7:0].
// word is a combinational view that already includes the incoming byte, so it is valid with word_full.
module boot_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_stb,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  idx;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx     <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_stb) begin
      idx     <= idx + 2'd1;
      shift_q <= {byte_in, shift_q[23:8]};
    end
  end

  assign word      = {byte_in, shift_q};
  assign word_full = byte_stb && (idx == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Framed image loader: BASE, COUNT, LE data words, optional XOR checksum; holds the core
// in reset until the whole image is written and verified.
//
// state   | meaning
// S_BASE  | collecting the 4-byte base address
// S_COUNT | collecting the 4-byte word count, then alignment/bounds check
// S_DATA  | collecting the bytes of the next data word
// S_WRITE | one-cycle memory write strobe for the assembled word
// S_CSUM  | waiting for the checksum byte
// S_DONE  | image accepted, core released (terminal)
// S_ERR   | frame rejected, core held (terminal)
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter bit CSUM_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam logic [34:0] MEM_LIMIT = 35'(MEM_BYTES);

  logic [2:0]  state;
  logic [31:0] base_q;
  logic [31:0] addr_q;
  logic [31:0] remaining_q;
  logic [7:0]  csum_q;
  logic        fire;
  logic        asm_clear;
  logic [31:0] word;
  logic        word_full;
  logic [34:0] end_addr;
  logic [2:0]  after_payload;

  assign in_ready = reset && ((state == S_BASE) || (state == S_COUNT) ||
                              (state == S_DATA) || (state == S_CSUM));
  assign fire      = in_valid && in_ready;
  assign mem_we    = reset && (state == S_WRITE);
  assign done      = reset && (state == S_DONE);
  assign error     = reset && (state == S_ERR);
  assign core_hold = !done;

  assign asm_clear     = (state == S_DONE) || (state == S_ERR);
  assign after_payload = CSUM_EN ? S_CSUM : S_DONE;

  // 35 bits so a huge COUNT cannot wrap the end address back into range.
  assign end_addr = {3'b000, base_q} + {1'b0, word, 2'b00};

  boot_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .byte_stb  (fire && (state != S_CSUM)),
    .clear     (asm_clear),
    .byte_in   (in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_BASE;
      base_q      <= 32'd0;
      addr_q      <= 32'd0;
      remaining_q <= 32'd0;
      csum_q      <= 8'd0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
    end else begin
      case (state)
        S_BASE: begin
          if (word_full) begin
            base_q <= word;
            state  <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (word_full) begin
            if (base_q[1:0] != 2'b00) begin
              state <= S_ERR;
            end else if (end_addr > MEM_LIMIT) begin
              state <= S_ERR;
            end else if (word == 32'd0) begin
              state <= after_payload;
            end else begin
              addr_q      <= base_q;
              remaining_q <= word;
              state       <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (fire) begin
            csum_q <= csum_q ^ in_data;
            if (word_full) begin
              mem_addr  <= addr_q;
              mem_wdata <= word;
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          addr_q      <= addr_q + 32'd4;
          remaining_q <= remaining_q - 32'd1;
          state       <= (remaining_q == 32'd1) ? after_payload : S_DATA;
        end
        S_CSUM: begin
          if (fire) state <= (in_data == csum_q) ? S_DONE : S_ERR;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a table of whole frames with expected outcome and writes,
// plus hand sequences for write/done latency and a reset in the middle of a data word.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, mem_we, core_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  boot_loader #(.MEM_BYTES(4096), .CSUM_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic [31:0] base;
    logic [31:0] count;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          bad_csum;
    logic [7:0]  csum;
    bit          hdr_only;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  bit          rand_gap = 1'b0;
  bit          stalled = 1'b0;
  bit          both_seen = 1'b0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  vec_t        vecs[9];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (done && error) both_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [7:0] xor_word(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  task automatic do_reset(input bit check_state);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check_state) begin
      check("reset in_ready", in_ready, 0);
      check("reset core_hold", core_hold, 1);
      check("reset done", done, 0);
      check("reset error", error, 0);
      check("reset mem_we", mem_we, 0);
      check("reset mem_addr", mem_addr, 0);
      check("reset mem_wdata", mem_wdata, 0);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (rand_gap) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) stalled = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic run_vec(input vec_t v, input int id, input bit skip_reset);
    logic [7:0]  cs;
    logic [31:0] wexp;
    int          g;
    if (!skip_reset) do_reset(0);
    send_word(v.base);
    send_word(v.count);
    if (!v.hdr_only) begin
      cs = 8'd0;
      for (int i = 0; i < int'(v.count); i++) begin
        wexp = (i == 0) ? v.w0 : v.w1;
        cs = cs ^ xor_word(wexp);
        send_word(wexp);
      end
      send_byte(v.bad_csum ? v.csum : cs);
    end
    g = 0;
    while (!(done || error) && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check($sformatf("v%0d done", id), done, v.exp_done);
    check($sformatf("v%0d error", id), error, v.exp_err);
    check($sformatf("v%0d core_hold", id), core_hold, !v.exp_done);
    check($sformatf("v%0d in_ready", id), in_ready, 0);
    check($sformatf("v%0d write count", id), wr_addr_q.size(), v.exp_wr);
    for (int i = 0; i < v.exp_wr && i < wr_addr_q.size(); i++) begin
      check($sformatf("v%0d write%0d addr", id, i), wr_addr_q[i], v.base + 32'(4 * i));
      check($sformatf("v%0d write%0d data", id, i), wr_data_q[i], (i == 0) ? v.w0 : v.w1);
    end
  endtask

  initial begin
    //          base         count          w0            w1            bad  csum  hdr  done err wr
    vecs[0] = '{32'h24,      32'd2,         32'h00100513, 32'h00500293, 0,   8'h00, 0,   1,   0,  2};
    vecs[1] = '{32'h24,      32'd2,         32'h00100513, 32'h00500293, 1,   8'h00, 0,   0,   1,  2};
    vecs[2] = '{32'h26,      32'd1,         32'h0,        32'h0,        0,   8'h00, 1,   0,   1,  0};
    vecs[3] = '{32'hFFC,     32'd2,         32'h0,        32'h0,        0,   8'h00, 1,   0,   1,  0};
    vecs[4] = '{32'hFFC,     32'd1,         32'hDEADBEEF, 32'h0,        0,   8'h00, 0,   1,   0,  1};
    vecs[5] = '{32'h0,       32'd0,         32'h0,        32'h0,        1,   8'h00, 0,   1,   0,  0};
    vecs[6] = '{32'h0,       32'h40000000,  32'h0,        32'h0,        0,   8'h00, 1,   0,   1,  0};
    vecs[7] = '{32'hFF8,     32'd2,         32'hA5A5F00F, 32'h12345678, 0,   8'h00, 0,   1,   0,  2};
    vecs[8] = '{32'h0,       32'd0,         32'h0,        32'h0,        1,   8'h5A, 0,   0,   1,  0};

    do_reset(1);

    // Latency: write strobe one cycle after the 4th data byte, done one cycle after CSUM.
    send_word(32'h24);
    send_word(32'd1);
    send_word(32'h00100513);
    check("lat mem_we", mem_we, 1);
    check("lat mem_addr", mem_addr, 32'h24);
    check("lat mem_wdata", mem_wdata, 32'h00100513);
    check("lat in_ready during write", in_ready, 0);
    @(posedge clk);
    #1;
    check("lat mem_we drops", mem_we, 0);
    check("lat mem_addr holds", mem_addr, 32'h24);
    check("lat done before csum", done, 0);
    send_byte(xor_word(32'h00100513));
    check("lat done", done, 1);
    check("lat core_hold", core_hold, 0);

    // Reset after two data bytes: partial word discarded, next frame loads cleanly.
    do_reset(0);
    send_word(32'h100);
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort no write", wr_addr_q.size(), 0);
    check("abort mem_we", mem_we, 0);
    check("abort core_hold", core_hold, 1);
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[0], 100, 1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i, 0);
    rand_gap = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(vecs[i], 10 + i, 0);

    check("done/error exclusive", both_seen, 0);
    check("no byte stalled", stalled, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
